// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// datapath select encodings and the one-hot instruction class.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_TRAP = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_BRANCH = 2'd1,
    ALU_FUNCT  = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } alu_src_b_t;

  typedef enum logic [1:0] {
    NPC_PLUS4 = 2'd0,
    NPC_IMM   = 2'd1,
    NPC_JALR  = 2'd2
  } next_pc_sel_t;

  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic ecall;
    logic illegal;
  } inst_class_t;

  // Target PC selection for instructions that retire in WB.
  function automatic next_pc_sel_t wb_next_pc(input inst_class_t c);
    if (c.jal)       return NPC_IMM;
    else if (c.jalr) return NPC_JALR;
    else             return NPC_PLUS4;
  endfunction

endpackage

// File: rtl/rv32i_opcode_decode.sv
// Combinational opcode classifier: maps inst[6:0] to a one-hot instruction class.
// Any opcode outside the supported RV32I subset is flagged illegal.
module rv32i_opcode_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0]  i_opcode,
  output inst_class_t o_class
);

  always_comb begin
    o_class = '0;
    case (i_opcode)
      OPC_R:      o_class.r       = 1'b1;
      OPC_I:      o_class.i       = 1'b1;
      OPC_LOAD:   o_class.load    = 1'b1;
      OPC_STORE:  o_class.store   = 1'b1;
      OPC_BRANCH: o_class.branch  = 1'b1;
      OPC_JAL:    o_class.jal     = 1'b1;
      OPC_JALR:   o_class.jalr    = 1'b1;
      OPC_SYSTEM: o_class.ecall   = 1'b1;
      default:    o_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// FSM control unit for the multi-cycle RV32I CPU (IF/ID/EX/MEM/WB plus HALT/TRAP),
// with cycle and retired-instruction counters. Optional feature macro: ILLEGAL_TRAP_EN.
module multi_cycle_control_unit
  import rv32i_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst,
  input  logic              mem_ready,
  input  logic              bcond,
  input  logic              halt_cond,
  output logic              mem_read,
  output logic              mem_write,
  output logic              i_or_d,
  output logic              ir_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic              reg_write,
  output logic              mem_to_reg,
  output logic              pc_to_reg,
  output logic              pc_write,
  output logic [1:0]        next_pc_sel,
  output logic              is_halted,
`ifdef ILLEGAL_TRAP_EN
  output logic              illegal_inst,
`endif
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_next;
  logic              r_boot;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [CNT_W-1:0]  r_instret_count;
  inst_class_t       w_class;
  logic              w_unused_inst;

  assign w_unused_inst = ^inst[INST_W-1:7];

  rv32i_opcode_decode u_decode (
    .i_opcode (inst[6:0]),
    .o_class  (w_class)
  );

  // r_boot marks the single idle cycle after reset: state is IF but nothing is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IF;
      r_boot  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_boot  <= 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_or_d       = 1'b0;
    ir_write     = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    pc_to_reg    = 1'b0;
    pc_write     = 1'b0;
    next_pc_sel  = NPC_PLUS4;
    if (!r_boot) begin
      unique case (r_state)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          if (mem_ready) w_state_next = S_ID;
        end
        S_ID: begin
          if (w_class.ecall) begin
            if (halt_cond) begin
              w_state_next = S_HALT;
            end else begin
              pc_write     = 1'b1;
              w_state_next = S_IF;
            end
          end else if (w_class.illegal) begin
`ifdef ILLEGAL_TRAP_EN
            w_state_next = S_TRAP;
`else
            pc_write     = 1'b1;
            w_state_next = S_IF;
`endif
          end else begin
            w_state_next = S_EX;
          end
        end
        S_EX: begin
          if (w_class.branch) begin
            alu_op       = ALU_BRANCH;
            pc_write     = 1'b1;
            next_pc_sel  = bcond ? NPC_IMM : NPC_PLUS4;
            w_state_next = S_IF;
          end else if (w_class.load || w_class.store) begin
            alu_src_a    = 1'b1;
            alu_src_b    = SRCB_IMM;
            alu_op       = ALU_ADD;
            w_state_next = S_MEM;
          end else if (w_class.r) begin
            alu_src_a    = 1'b1;
            alu_src_b    = SRCB_RS2;
            alu_op       = ALU_FUNCT;
            w_state_next = S_WB;
          end else if (w_class.i) begin
            alu_src_a    = 1'b1;
            alu_src_b    = SRCB_IMM;
            alu_op       = ALU_FUNCT;
            w_state_next = S_WB;
          end else begin
            w_state_next = S_WB;
          end
        end
        S_MEM: begin
          i_or_d = 1'b1;
          if (w_class.load) begin
            mem_read = 1'b1;
            if (mem_ready) w_state_next = S_WB;
          end else if (w_class.store) begin
            mem_write = 1'b1;
            if (mem_ready) begin
              pc_write     = 1'b1;
              w_state_next = S_IF;
            end
          end else begin
            w_state_next = S_IF;
          end
        end
        S_WB: begin
          reg_write    = 1'b1;
          pc_write     = 1'b1;
          mem_to_reg   = w_class.load;
          pc_to_reg    = w_class.jal | w_class.jalr;
          next_pc_sel  = wb_next_pc(w_class);
          w_state_next = S_IF;
        end
        S_HALT: w_state_next = S_HALT;
        S_TRAP: w_state_next = S_TRAP;
        default: w_state_next = S_IF;
      endcase
    end
  end

  // Counters are frozen in HALT/TRAP and during the post-reset idle cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count   <= '0;
      r_instret_count <= '0;
    end else begin
      if (!r_boot && r_state != S_HALT && r_state != S_TRAP)
        r_cycle_count <= r_cycle_count + CNT_ONE;
      if (pc_write)
        r_instret_count <= r_instret_count + CNT_ONE;
    end
  end

  assign cycle_count   = r_cycle_count;
  assign instret_count = r_instret_count;
  assign is_halted     = (r_state == S_HALT);
`ifdef ILLEGAL_TRAP_EN
  assign illegal_inst  = (r_state == S_TRAP);
`endif

endmodule
